// File: rtl/lcd_string_driver_pkg.sv
// Shared definitions for the HD44780 string driver: command opcodes,
// init nibbles, main-sequencer and byte-transmitter state encodings.
// No ports; imported by lcd_byte_tx and lcd_string_driver.
package lcd_string_driver_pkg;

    // HD44780 command opcodes (all sent with RS=0)
    localparam logic [7:0] CMD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

    // Single nibbles of the power-on wake-up sequence
    localparam logic [3:0] NIB_WAKE  = 4'h3;
    localparam logic [3:0] NIB_4BIT  = 4'h2;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CFG,
        IDLE,
        REFRESH
    } main_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHI,
        TX_GAP,
        TX_WAIT
    } tx_state_e;

    // Configuration byte sent at step i of the CFG phase
    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    cfg_byte = CMD_FUNC_SET;
            2'd1:    cfg_byte = CMD_ENTRY;
            2'd2:    cfg_byte = CMD_DISP_ON;
            default: cfg_byte = CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (two nibbles) or one nibble to the LCD, then waits wait_cycles_i.
// Latency: start accepted in TX_IDLE or on the done cycle; done_o pulses on the last wait cycle.
// No backpressure: start_i is ignored while a transfer is in flight.
// Ports: clk_i/rst_i; start_i, rs_i, byte_i, nibble_only_i (sends byte_i[3:0]),
// wait_cycles_i; done_o; LCD pins rs_o, e_o, d_o.
module lcd_byte_tx
    import lcd_string_driver_pkg::*;
#(
    parameter int T_SETUP      = 2,
    parameter int T_E_HIGH     = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int CNT_W        = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             rs_i,
    input  logic [7:0]       byte_i,
    input  logic             nibble_only_i,
    input  logic [CNT_W-1:0] wait_cycles_i,
    output logic             done_o,
    output logic             rs_o,
    output logic             e_o,
    output logic [3:0]       d_o
);

    tx_state_e        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic [3:0]       d_q, d_d;
    logic [3:0]       lo_q, lo_d;
    logic             lo_pend_q, lo_pend_d;
    logic             last;
    logic             accept;

    // A phase loaded with N lasts exactly N cycles: it ends when the count reads 1.
    assign last = (cnt_q == CNT_W'(1));

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        rs_d      = rs_q;
        e_d       = e_q;
        d_d       = d_q;
        lo_d      = lo_q;
        lo_pend_d = lo_pend_q;
        done_o    = 1'b0;
        accept    = 1'b0;

        case (phase_q)
            TX_IDLE: accept = start_i;
            TX_SETUP: begin
                if (last) begin
                    phase_d = TX_EHI;
                    cnt_d   = CNT_W'(T_E_HIGH);
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TX_EHI: begin
                if (last) begin
                    e_d = 1'b0;
                    if (lo_pend_q) begin
                        phase_d = TX_GAP;
                        cnt_d   = CNT_W'(T_NIBBLE_GAP);
                    end else begin
                        phase_d = TX_WAIT;
                        cnt_d   = wait_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TX_GAP: begin
                // Low nibble appears on the bus at the start of its own setup time
                if (last) begin
                    phase_d   = TX_SETUP;
                    cnt_d     = CNT_W'(T_SETUP);
                    d_d       = lo_q;
                    lo_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TX_WAIT: begin
                if (last) begin
                    done_o  = 1'b1;
                    phase_d = TX_IDLE;
                    // Back-to-back start keeps byte spacing free of idle cycles
                    accept  = start_i;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: phase_d = TX_IDLE;
        endcase

        if (accept) begin
            phase_d = TX_SETUP;
            cnt_d   = CNT_W'(T_SETUP);
            rs_d    = rs_i;
            lo_d    = byte_i[3:0];
            wait_d  = wait_cycles_i;
            if (nibble_only_i) begin
                d_d       = byte_i[3:0];
                lo_pend_d = 1'b0;
            end else begin
                d_d       = byte_i[7:4];
                lo_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q   <= TX_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            rs_q      <= 1'b0;
            e_q       <= 1'b0;
            d_q       <= 4'h0;
            lo_q      <= 4'h0;
            lo_pend_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            rs_q      <= rs_d;
            e_q       <= e_d;
            d_q       <= d_d;
            lo_q      <= lo_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    assign rs_o = rs_q;
    assign e_o  = e_q;
    assign d_o  = d_q;

endmodule

// File: rtl/lcd_string_driver.sv
// HD44780 4-bit write-only driver: power-on init, then rewrites both 16-char lines per cls request.
// Latency: first E rise T_SETUP cycles after busy rises; refresh = 34 byte times.
// No backpressure: cls requests during init/refresh collapse into one pending refresh.
// Ports: CCLK, rst (async, active-high); cls, strdata[255:0] (char k at [255-8k -: 8]);
// rslcd, rwlcd (tied 0), elcd, lcdd[3:0] to the LCD; busy high unless idle.
module lcd_string_driver
    import lcd_string_driver_pkg::*;
#(
    parameter int T_POWERUP    = 750000,
    parameter int T_INIT1      = 205000,
    parameter int T_INIT2      = 5000,
    parameter int T_CMD        = 2000,
    parameter int T_CLEAR      = 82000,
    parameter int T_SETUP      = 2,
    parameter int T_E_HIGH     = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int CNT_W        = 20
) (
    input  logic         CCLK,
    input  logic         rst,
    input  logic         cls,
    input  logic [255:0] strdata,
    output logic         rslcd,
    output logic         rwlcd,
    output logic         elcd,
    output logic [3:0]   lcdd,
    output logic         busy
);

    localparam logic [CNT_W-1:0] W_INIT1 = CNT_W'(T_INIT1);
    localparam logic [CNT_W-1:0] W_INIT2 = CNT_W'(T_INIT2);
    localparam logic [CNT_W-1:0] W_CMD   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] W_CLEAR = CNT_W'(T_CLEAR);

    main_state_e      state_q, state_d;
    logic [5:0]       idx_q, idx_d;      // step currently in flight within a phase
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [255:0]     frame_q, frame_d;

    logic             tx_start, tx_rs, tx_nib, tx_done;
    logic [7:0]       tx_byte;
    logic [CNT_W-1:0] tx_wait;
    logic [5:0]       nxt_idx;
    logic [4:0]       char_sel;

    assign nxt_idx  = idx_q + 6'd1;
    // Refresh steps 1..16 carry chars 0..15; step 17 is LINE2; 18..33 carry 16..31
    assign char_sel = (nxt_idx <= 6'd16) ? 5'(nxt_idx - 6'd1) : 5'(nxt_idx - 6'd2);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        pcnt_d   = pcnt_q;
        frame_d  = frame_q;
        tx_start = 1'b0;
        tx_rs    = 1'b0;
        tx_nib   = 1'b0;
        tx_byte  = 8'h00;
        tx_wait  = W_CMD;

        if (state_q != IDLE && cls) begin
            pend_d = 1'b1;
        end

        case (state_q)
            PWR_WAIT: begin
                pcnt_d = pcnt_q + CNT_W'(1);
                // Launch on the last power-up cycle so the nibble starts right after it
                if (pcnt_q == CNT_W'(T_POWERUP - 1)) begin
                    state_d  = INIT;
                    idx_d    = 6'd0;
                    tx_start = 1'b1;
                    tx_nib   = 1'b1;
                    tx_byte  = {4'h0, NIB_WAKE};
                    tx_wait  = W_INIT1;
                end
            end
            INIT: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    idx_d    = nxt_idx;
                    if (idx_q == 6'd3) begin
                        state_d = CFG;
                        idx_d   = 6'd0;
                        tx_byte = cfg_byte(2'd0);
                    end else begin
                        tx_nib  = 1'b1;
                        tx_byte = {4'h0, (idx_q == 6'd2) ? NIB_4BIT : NIB_WAKE};
                        tx_wait = (idx_q == 6'd0) ? W_INIT2 : W_CMD;
                    end
                end
            end
            CFG: begin
                if (tx_done) begin
                    if (idx_q == 6'd3) begin
                        state_d = IDLE;
                    end else begin
                        tx_start = 1'b1;
                        idx_d    = nxt_idx;
                        tx_byte  = cfg_byte(nxt_idx[1:0]);
                        tx_wait  = (idx_q == 6'd2) ? W_CLEAR : W_CMD;
                    end
                end
            end
            IDLE: begin
                if (cls || pend_q) begin
                    frame_d  = strdata;
                    pend_d   = 1'b0;
                    state_d  = REFRESH;
                    idx_d    = 6'd0;
                    tx_start = 1'b1;
                    tx_byte  = CMD_LINE1;
                end
            end
            REFRESH: begin
                if (tx_done) begin
                    if (idx_q == 6'd33) begin
                        state_d = IDLE;
                    end else begin
                        tx_start = 1'b1;
                        idx_d    = nxt_idx;
                        if (nxt_idx == 6'd17) begin
                            tx_byte = CMD_LINE2;
                        end else begin
                            tx_rs   = 1'b1;
                            // MSB of char k is bit 255-8k = {~k, 3'b111}
                            tx_byte = frame_q[{~char_sel, 3'b111} -: 8];
                        end
                    end
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            state_q <= PWR_WAIT;
            idx_q   <= 6'd0;
            pend_q  <= 1'b0;
            pcnt_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            pcnt_q  <= pcnt_d;
            frame_q <= frame_d;
        end
    end

    lcd_byte_tx #(
        .T_SETUP      (T_SETUP),
        .T_E_HIGH     (T_E_HIGH),
        .T_NIBBLE_GAP (T_NIBBLE_GAP),
        .CNT_W        (CNT_W)
    ) u_tx (
        .clk_i         (CCLK),
        .rst_i         (rst),
        .start_i       (tx_start),
        .rs_i          (tx_rs),
        .byte_i        (tx_byte),
        .nibble_only_i (tx_nib),
        .wait_cycles_i (tx_wait),
        .done_o        (tx_done),
        .rs_o          (rslcd),
        .e_o           (elcd),
        .d_o           (lcdd)
    );

    assign rwlcd = 1'b0;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_string_driver.sv
module tb_lcd_string_driver;

    localparam int T_POWERUP = 20, T_INIT1 = 10, T_INIT2 = 6, T_CMD = 4, T_CLEAR = 8;
    localparam int T_SETUP = 1, T_E_HIGH = 2, T_NIBBLE_GAP = 3;
    localparam int NIB_T   = T_SETUP + T_E_HIGH;
    localparam int BYTE_T  = 2 * NIB_T + T_NIBBLE_GAP + T_CMD;
    localparam int INIT_T  = T_POWERUP + 4 * NIB_T + T_INIT1 + T_INIT2 + 2 * T_CMD
                           + 3 * BYTE_T + (2 * NIB_T + T_NIBBLE_GAP + T_CLEAR);
    localparam int REFR_T  = 34 * BYTE_T;

    logic         CCLK = 1'b0;
    logic         rst, cls;
    logic [255:0] strdata;
    logic         rslcd, rwlcd, elcd, busy;
    logic [3:0]   lcdd;

    lcd_string_driver #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
        .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH),
        .T_NIBBLE_GAP(T_NIBBLE_GAP), .CNT_W(20)
    ) dut (
        .CCLK(CCLK), .rst(rst), .cls(cls), .strdata(strdata),
        .rslcd(rslcd), .rwlcd(rwlcd), .elcd(elcd), .lcdd(lcdd), .busy(busy)
    );

    always #5 CCLK = ~CCLK;

    int cyc = 0;
    always @(posedge CCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected strobes
    typedef struct {
        logic       nib;
        logic       rs;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_init();
        exp_t tab[8];
        tab[0] = '{1'b1, 1'b0, 8'h03};
        tab[1] = '{1'b1, 1'b0, 8'h03};
        tab[2] = '{1'b1, 1'b0, 8'h03};
        tab[3] = '{1'b1, 1'b0, 8'h02};
        tab[4] = '{1'b0, 1'b0, 8'h28};
        tab[5] = '{1'b0, 1'b0, 8'h06};
        tab[6] = '{1'b0, 1'b0, 8'h0C};
        tab[7] = '{1'b0, 1'b0, 8'h01};
        for (int i = 0; i < 8; i++) exp_q.push_back(tab[i]);
    endtask

    task automatic push_refresh(input logic [255:0] f);
        exp_q.push_back('{1'b0, 1'b0, 8'h80});
        for (int k = 0; k < 32; k++) begin
            if (k == 16) exp_q.push_back('{1'b0, 1'b0, 8'hC0});
            exp_q.push_back('{1'b0, 1'b1, f[8'(255 - 8 * k) -: 8]});
        end
    endtask

    // Strobe monitor: samples on the falling edge, away from the active edge
    logic prev_e = 1'b0, half = 1'b0, hi_rs, held_rs;
    logic [3:0] hi_d, held_d;
    int   hi_cyc, arm_cyc, arm_delta;
    logic armed = 1'b0;
    exp_t e;

    always @(negedge CCLK) begin
        if (rst) begin
            half   = 1'b0;
            prev_e = elcd;
        end else begin
            if (elcd && !prev_e) begin
                if (armed) begin
                    chk("first_strobe_delay", 32'(cyc - arm_cyc), 32'(arm_delta));
                    armed = 1'b0;
                end
                held_rs = rslcd;
                held_d  = lcdd;
                chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    if (exp_q[0].nib) begin
                        e = exp_q.pop_front();
                        chk("init_nibble", {27'd0, rslcd, lcdd}, {27'd0, e.rs, e.val[3:0]});
                    end else if (!half) begin
                        hi_d   = lcdd;
                        hi_rs  = rslcd;
                        hi_cyc = cyc;
                        half   = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", {22'd0, hi_rs, rslcd, hi_d, lcdd}, {22'd0, e.rs, e.rs, e.val});
                        chk("nibble_spacing", 32'(cyc - hi_cyc), 32'(NIB_T + T_NIBBLE_GAP));
                        half = 1'b0;
                    end
                end
            end else if (elcd && prev_e) begin
                chk("hold_while_e", {27'd0, rslcd, lcdd}, {27'd0, held_rs, held_d});
            end
            prev_e = elcd;
        end
    end

    task automatic wait_busy(input logic lvl, input int limit, input string name, output int at);
        int n;
        n  = 0;
        at = 0;
        while (busy !== lvl && n < limit) begin
            @(negedge CCLK);
            n++;
        end
        if (busy !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required %b", name, busy, n, lvl);
        end else begin
            at = cyc;
        end
    endtask

    // Called at a falling edge; returns the cycle number of the edge that sampled cls
    task automatic start_refresh(input logic [255:0] f, input logic keep, output int p);
        strdata = f;
        cls     = 1'b1;
        @(negedge CCLK);
        p = cyc;
        if (!keep) cls = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        arm_cyc   = p;
        arm_delta = T_SETUP;
        armed     = 1'b1;
    endtask

    typedef struct {
        logic [255:0] frame;
        logic [255:0] late;
        int           late_at;
        logic [255:0] shown;
    } vec_t;

    logic [255:0] alpha, hello, xs, fa, fb, fc;
    vec_t vecs[3];
    int   p, at, at2, n0, lows;

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        alpha = "0123456789abcdefghijklmnopqrstuv";
        hello = "Hello, World!   pipelined CPU OK";
        xs    = {32{8'h58}};
        fa    = "AAAAAAAAAAAAAAAAaaaaaaaaaaaaaaaa";
        fb    = "BBBBBBBBBBBBBBBBbbbbbbbbbbbbbbbb";
        fc    = "CCCCCCCCCCCCCCCC~!@#$%^&*()_+=-<";
        vecs[0] = '{alpha, alpha, 0, alpha};
        vecs[1] = '{alpha, xs, 5, alpha};
        vecs[2] = '{hello, hello, 0, hello};

        rst = 1'b1;
        cls = 1'b0;
        strdata = '0;
        repeat (3) @(negedge CCLK);
        chk("rst_rslcd", 32'(rslcd), 32'd0);
        chk("rst_rwlcd", 32'(rwlcd), 32'd0);
        chk("rst_elcd", 32'(elcd), 32'd0);
        chk("rst_lcdd", 32'(lcdd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Power-on init
        rst = 1'b0;
        n0  = cyc;
        push_init();
        arm_cyc   = n0;
        arm_delta = T_POWERUP + T_SETUP;
        armed     = 1'b1;
        wait_busy(1'b0, INIT_T + 50, "init_done", at);
        chk("init_length", 32'(at - n0), 32'(INIT_T));
        chk("init_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rwlcd_tied", 32'(rwlcd), 32'd0);

        // Table-driven refreshes
        for (int i = 0; i < 3; i++) begin
            @(negedge CCLK);
            push_refresh(vecs[i].shown);
            start_refresh(vecs[i].frame, 1'b0, p);
            if (vecs[i].late_at > 0) begin
                repeat (vecs[i].late_at - 1) @(negedge CCLK);
                strdata = vecs[i].late;
            end
            wait_busy(1'b0, REFR_T + 50, "refresh_done", at);
            chk("refresh_length", 32'(at - p), 32'(REFR_T));
            chk("refresh_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Two requests during one refresh collapse into a single follow-up
        @(negedge CCLK);
        push_refresh(fa);
        push_refresh(fc);
        start_refresh(fa, 1'b0, p);
        repeat (30) @(negedge CCLK);
        strdata = fb;
        cls = 1'b1;
        @(negedge CCLK);
        cls = 1'b0;
        repeat (50) @(negedge CCLK);
        strdata = fc;
        cls = 1'b1;
        @(negedge CCLK);
        cls = 1'b0;
        wait_busy(1'b0, REFR_T + 50, "pend_first_done", at);
        chk("pend_first_length", 32'(at - p), 32'(REFR_T));
        wait_busy(1'b1, 5, "pend_restart", at2);
        chk("pend_idle_gap", 32'(at2 - at), 32'd1);
        wait_busy(1'b0, REFR_T + 50, "pend_second_done", at);
        chk("pend_second_length", 32'(at - at2), 32'(REFR_T));
        repeat (30) @(negedge CCLK);
        chk("pend_no_third", 32'(busy), 32'd0);
        chk("pend_queue_empty", 32'(exp_q.size()), 32'd0);

        // cls held high: back-to-back refreshes with one idle cycle between
        @(negedge CCLK);
        push_refresh(hello);
        push_refresh(hello);
        start_refresh(hello, 1'b1, p);
        wait_busy(1'b0, REFR_T + 50, "b2b_first_done", at);
        chk("b2b_first_length", 32'(at - p), 32'(REFR_T));
        lows = 0;
        while (busy == 1'b0 && lows < 5) begin
            chk("b2b_idle_elcd", 32'(elcd), 32'd0);
            lows++;
            @(negedge CCLK);
        end
        chk("b2b_idle_cycles", 32'(lows), 32'd1);
        cls = 1'b0;
        wait_busy(1'b0, REFR_T + 50, "b2b_second_done", at);
        repeat (30) @(negedge CCLK);
        chk("b2b_stays_idle", 32'(busy), 32'd0);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while E is high mid-refresh
        @(negedge CCLK);
        push_refresh(alpha);
        start_refresh(alpha, 1'b0, p);
        repeat (100) @(negedge CCLK);
        n0 = 0;
        while (elcd !== 1'b1 && n0 < 20) begin
            @(negedge CCLK);
            n0++;
        end
        chk("elcd_high_before_reset", 32'(elcd), 32'd1);
        rst = 1'b1;
        #1;
        chk("reset_elcd_immediate", 32'(elcd), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        exp_q.delete();
        armed = 1'b0;
        repeat (3) @(negedge CCLK);
        rst = 1'b0;
        n0  = cyc;
        push_init();
        arm_cyc   = n0;
        arm_delta = T_POWERUP + T_SETUP;
        armed     = 1'b1;
        wait_busy(1'b0, INIT_T + 50, "reinit_done", at);
        chk("reinit_length", 32'(at - n0), 32'(INIT_T));
        chk("reinit_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
